// File: rtl/ws2812_channel_serializer_pkg.sv
// Shared definitions for the WS2812 channel serializer.
// Holds the FSM state encoding, default timing constants for a 50 MHz clock
// and a helper that sizes counters so that a count of 1 still gets one bit.
package ws2812_channel_serializer_pkg;

  localparam int unsigned DefNumChannels = 5;
  localparam int unsigned DefPixelBits   = 24;
  localparam int unsigned DefBitCycles   = 63;    // 1.25 us
  localparam int unsigned DefT0hCycles   = 20;
  localparam int unsigned DefT1hCycles   = 40;
  localparam int unsigned DefLatchCycles = 2800;  // 56 us

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_channel_serializer_if.sv
// Pixel stream interface: valid/ready transfer of one pixel word plus an
// end-of-strand marker.
//   pix_data  - pixel word, MSB transmitted first
//   pix_last  - this pixel ends the strand
//   pix_valid - source has a pixel
//   pix_ready - sink takes the pixel when pix_valid & pix_ready
interface ws2812_channel_serializer_if
  import ws2812_channel_serializer_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = DefPixelBits
) ();

  logic [PIXEL_BITS-1:0] pix_data;
  logic                  pix_last;
  logic                  pix_valid;
  logic                  pix_ready;

  modport master (
    output pix_data,
    output pix_last,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_last,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/ws2812_channel_serializer_bit_timer.sv
// Bit-period timer for the WS2812 serializer.
// Counts cyc over 0..BIT_CYCLES-1 while run is high and decides whether the
// line is in the high part of the current bit.
//   clk, rst   - clock, asynchronous active-high reset
//   run        - a bit is being transmitted this cycle
//   start      - restart the bit period at cyc=0 on the next cycle
//   bit_val    - value of the bit currently being sent
//   line_high  - current cycle lies inside the high time of the bit
//   bit_end    - current cycle is the last one of the bit period
module ws2812_channel_serializer_bit_timer
  import ws2812_channel_serializer_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DefBitCycles,
  parameter int unsigned T0H_CYCLES = DefT0hCycles,
  parameter int unsigned T1H_CYCLES = DefT1hCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic start,
  input  logic bit_val,
  output logic line_high,
  output logic bit_end
);

  localparam int unsigned     CycW    = cnt_width(BIT_CYCLES);
  localparam logic [CycW-1:0] CycLast = CycW'(BIT_CYCLES - 1);
  localparam logic [CycW-1:0] T0h     = CycW'(T0H_CYCLES);
  localparam logic [CycW-1:0] T1h     = CycW'(T1H_CYCLES);

  logic [CycW-1:0] cyc_q, cyc_d;
  logic [CycW-1:0] thigh;

  always_comb begin
    thigh     = bit_val ? T1h : T0h;
    line_high = run && (cyc_q < thigh);
    bit_end   = run && (cyc_q == CycLast);
    // Counter parks at zero when idle so a fresh bit always starts at cyc=0.
    if (start || !run || bit_end) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + CycW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/ws2812_channel_serializer.sv
// WS2812 channel serializer.
// Turns a valid/ready stream of pixels into WS2812 NRZ waveforms on the LED
// lines picked by a one-hot channel select, holds all lines low for the
// latch time after the last pixel of a strand, then strobes chan_done so the
// channel counter advances.
//   clk, rst   - clock, asynchronous active-high reset
//   sel        - channel select, sampled at each pixel accept
//   pix        - pixel stream (slave side)
//   dout       - registered LED data lines
//   busy       - high from pixel accept until the strand has finished
//   chan_done  - one-cycle strobe after the latch time
module ws2812_channel_serializer
  import ws2812_channel_serializer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = DefNumChannels,
  parameter int unsigned PIXEL_BITS   = DefPixelBits,
  parameter int unsigned BIT_CYCLES   = DefBitCycles,
  parameter int unsigned T0H_CYCLES   = DefT0hCycles,
  parameter int unsigned T1H_CYCLES   = DefT1hCycles,
  parameter int unsigned LATCH_CYCLES = DefLatchCycles
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CHANNELS-1:0]    sel,
  ws2812_channel_serializer_if.slave pix,
  output logic [NUM_CHANNELS-1:0]    dout,
  output logic                       busy,
  output logic                       chan_done
);

  localparam int unsigned       IdxW      = cnt_width(PIXEL_BITS);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(PIXEL_BITS - 1);
  localparam int unsigned       LatchW    = cnt_width(LATCH_CYCLES);
  localparam logic [LatchW-1:0] LatchLast = LatchW'(LATCH_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [PIXEL_BITS-1:0]   shreg_q, shreg_d;
  logic                    last_q, last_d;
  logic [NUM_CHANNELS-1:0] sel_q, sel_d;
  logic [IdxW-1:0]         bit_idx_q, bit_idx_d;
  logic [LatchW-1:0]       latch_cnt_q, latch_cnt_d;
  logic [NUM_CHANNELS-1:0] dout_q, dout_d;
  logic                    chan_done_q, chan_done_d;

  logic timer_run, timer_start, line_high, bit_end;
  logic final_bit_end, accept;

  ws2812_channel_serializer_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (timer_run),
    .start     (timer_start),
    .bit_val   (shreg_q[PIXEL_BITS-1]),
    .line_high (line_high),
    .bit_end   (bit_end)
  );

  assign timer_run     = (state_q == StShift);
  assign final_bit_end = bit_end && (bit_idx_q == '0);

  // Ready in the last cycle of a non-final pixel lets the next pixel follow
  // with no low gap between bit periods.
  assign pix.pix_ready = !rst && ((state_q == StIdle) ||
                                  (final_bit_end && !last_q));
  assign accept        = pix.pix_valid && pix.pix_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    last_d      = last_q;
    sel_d       = sel_q;
    bit_idx_d   = bit_idx_q;
    latch_cnt_d = latch_cnt_q;
    timer_start = 1'b0;

    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (bit_end) begin
          if (bit_idx_q != '0) begin
            shreg_d   = shreg_q << 1;
            bit_idx_d = bit_idx_q - IdxW'(1);
          end else if (last_q) begin
            state_d     = StLatch;
            latch_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLatch: begin
        if (latch_cnt_q == LatchLast) begin
          state_d = StDone;
        end else begin
          latch_cnt_d = latch_cnt_q + LatchW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Accept only occurs in IDLE or the final bit cycle; it overrides both.
    if (accept) begin
      state_d     = StShift;
      shreg_d     = pix.pix_data;
      last_d      = pix.pix_last;
      sel_d       = sel;
      bit_idx_d   = IdxLast;
      timer_start = 1'b1;
    end

    dout_d      = (timer_run && line_high) ? sel_q : '0;
    // Registered like dout so the strobe lands after the last low line cycle.
    chan_done_d = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      last_q      <= 1'b0;
      sel_q       <= '0;
      bit_idx_q   <= '0;
      latch_cnt_q <= '0;
      dout_q      <= '0;
      chan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      bit_idx_q   <= bit_idx_d;
      latch_cnt_q <= latch_cnt_d;
      dout_q      <= dout_d;
      chan_done_q <= chan_done_d;
    end
  end

  assign dout      = dout_q;
  assign chan_done = chan_done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ws2812_channel_serializer.sv
// Bench for ws2812_channel_serializer with short timing (bit 6, T0H 2, T1H 4,
// latch 10, 5 channels). Accepted pixels push their expected per-cycle line
// waveform and chan_done strobe into a scoreboard queue keyed by clock edge;
// a monitor compares dout/chan_done against it on every falling edge.
module tb_ws2812_channel_serializer;

  localparam int unsigned NCh   = 5;
  localparam int unsigned PBits = 24;
  localparam int unsigned BitC  = 6;
  localparam int unsigned T0hC  = 2;
  localparam int unsigned T1hC  = 4;
  localparam int unsigned LatC  = 10;
  localparam int unsigned PixC  = PBits * BitC;           // 144
  localparam int unsigned DoneC = PixC + LatC + 1;        // 155

  typedef struct {
    int unsigned    cyc;
    logic [NCh-1:0] dout;
    logic           done;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCh-1:0] sel;
  logic [NCh-1:0] dout;
  logic           busy;
  logic           chan_done;
  int unsigned    edge_n = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  exp_t           exp_q[$];

  ws2812_channel_serializer_if #(.PIXEL_BITS(PBits)) pix_if ();

  ws2812_channel_serializer #(
    .NUM_CHANNELS (NCh),
    .PIXEL_BITS   (PBits),
    .BIT_CYCLES   (BitC),
    .T0H_CYCLES   (T0hC),
    .T1H_CYCLES   (T1hC),
    .LATCH_CYCLES (LatC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .pix       (pix_if),
    .dout      (dout),
    .busy      (busy),
    .chan_done (chan_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected line activity of one pixel accepted on clock edge a.
  function automatic void model_pixel(input int unsigned a, input logic [NCh-1:0] s,
                                      input logic [PBits-1:0] d, input logic l);
    int unsigned th;
    for (int i = 0; i < int'(PBits); i++) begin
      th = d[PBits-1-i] ? T1hC : T0hC;
      for (int c = 0; c < int'(BitC); c++) begin
        exp_q.push_back('{cyc: a + 1 + i * BitC + c,
                          dout: (c < int'(th)) ? s : '0,
                          done: 1'b0});
      end
    end
    if (l) exp_q.push_back('{cyc: a + DoneC, dout: '0, done: 1'b1});
  endfunction

  // Monitor: one comparison of the line outputs per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: entry for edge %0d never compared (now %0d)", e.cyc, edge_n);
      end
      e = '{cyc: edge_n, dout: '0, done: 1'b0};
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_n) e = exp_q.pop_front();
      n_checks++;
      if (dout !== e.dout || chan_done !== e.done) begin
        n_fail++;
        $display("FAIL scoreboard edge %0d: dout=%b chan_done=%b, expected dout=%b chan_done=%b",
                 edge_n, dout, chan_done, e.dout, e.done);
      end
    end
  end

  // Offers a pixel from the next falling edge; returns the accepting edge.
  task automatic send(input logic [NCh-1:0] s, input logic [PBits-1:0] d, input logic l,
                      output int unsigned acc);
    int unsigned waited;
    waited = 0;
    acc    = 0;
    @(negedge clk);
    sel              = s;
    pix_if.pix_data  = d;
    pix_if.pix_last  = l;
    pix_if.pix_valid = 1'b1;
    while (pix_if.pix_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (pix_if.pix_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout: pix_ready=%b, expected 1", pix_if.pix_ready);
      pix_if.pix_valid = 1'b0;
    end else begin
      acc = edge_n + 1;
      model_pixel(acc, s, d, l);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    pix_if.pix_valid = 1'b0;
    check("busy after accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int unsigned acc, input string name);
    int unsigned waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (chan_done !== 1'b1 && waited < 300);
    check(name, edge_n - acc, DoneC);
    check("busy low at chan_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int unsigned a1, a2, npix, waited;
    logic [NCh-1:0] rs;
    rst = 1'b0;
    sel = '0;
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = '0;
    pix_if.pix_last  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset dout", {27'd0, dout}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset chan_done", {31'd0, chan_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("pix_ready after reset", {31'd0, pix_if.pix_ready}, 32'd1);

    // Single pixel, single line, strand end.
    send(5'b00100, 24'hA00000, 1'b1, a1);
    drop();
    wait_done(a1, "chan_done cycle single");

    // Two pixels back to back with valid held.
    send(5'b10000, 24'($urandom), 1'b0, a1);
    send(5'b10000, 24'($urandom), 1'b1, a2);
    check("zero gap accept spacing", a2 - a1, PixC);
    drop();
    wait_done(a2, "chan_done cycle pair");

    // sel moves mid-pixel; the sampled select must stay in force.
    send(5'b00100, 24'($urandom), 1'b1, a1);
    drop();
    repeat (29) @(negedge clk);
    sel = 5'b01000;
    wait_done(a1, "chan_done cycle sel change");

    // No line selected, then broadcast to two lines.
    send(5'b00000, 24'($urandom), 1'b1, a1);
    drop();
    wait_done(a1, "chan_done cycle sel zero");
    send(5'b00011, 24'($urandom), 1'b1, a1);
    drop();
    wait_done(a1, "chan_done cycle broadcast");

    // Random strands with random selects, lengths and gaps.
    for (int s = 0; s < 8; s++) begin
      npix = $urandom_range(1, 3);
      case ($urandom_range(0, 2))
        0:       rs = NCh'(1) << $urandom_range(0, NCh - 1);
        1:       rs = NCh'($urandom);
        default: rs = '0;
      endcase
      for (int p = 0; p < int'(npix); p++) begin
        send(rs, 24'($urandom), (p == int'(npix) - 1), a1);
        if (p == int'(npix) - 1 || $urandom_range(0, 1) == 1) begin
          drop();
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      wait_done(a1, "chan_done cycle random strand");
    end

    // Reset while a line is high.
    send(5'b00001, 24'hFFFFFF, 1'b1, a1);
    drop();
    waited = 0;
    while (dout[0] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("line high before reset", {31'd0, dout[0]}, 32'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("dout cleared by async reset", {27'd0, dout}, 32'd0);
    check("busy cleared by async reset", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("pix_ready after mid-run reset", {31'd0, pix_if.pix_ready}, 32'd1);

    repeat (200) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
